// File: rtl/max7219_display_if.sv
// Serial link to a MAX7219 daisy chain: clock, data and LOAD/CS.
interface max7219_display_if;
    logic spi_clk;
    logic dout;
    logic cs;

    modport master (output spi_clk, output dout, output cs);
    modport slave  (input spi_clk, input dout, input cs);
endinterface

// File: rtl/max7219_display.sv
// Continuously refreshes a chain of MAX7219 chips with a byte frame shown as hex digits.
// Optional macro MAX7219_REINIT_EN: resend the configuration commands before every refresh.
module max7219_display #(
    parameter int NUM_CASCADES = 1,
    parameter int INTENSITY    = 8,
    parameter int CLK_DIV      = 4,
    parameter int GAP_CYCLES   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        frame [4*NUM_CASCADES],
    max7219_display_if.master spi,
    output logic              stop,
    output logic [10:1]       pin
);
    localparam int NB = 4 * NUM_CASCADES;
    localparam int SW = 16 * NUM_CASCADES;
    localparam int FW = (NB > 1) ? $clog2(NB) : 1;
    localparam int DW = $clog2(2 * CLK_DIV + 1);
    localparam int BW = $clog2(SW + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HOLD_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SW - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [3:0]    INTENSITY_NIB = 4'(INTENSITY);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0, ST_LATCH = 3'd1, ST_DIGITS = 3'd2, ST_GAP = 3'd3
    } state_e;
    typedef enum logic [2:0] {
        PH_LOAD = 3'd0, PH_LOW = 3'd1, PH_HIGH = 3'd2, PH_TAIL = 3'd3, PH_HOLD = 3'd4
    } phase_e;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'h7E;  4'h1: seg7 = 8'h30;  4'h2: seg7 = 8'h6D;  4'h3: seg7 = 8'h79;
            4'h4: seg7 = 8'h33;  4'h5: seg7 = 8'h5B;  4'h6: seg7 = 8'h5F;  4'h7: seg7 = 8'h70;
            4'h8: seg7 = 8'h7F;  4'h9: seg7 = 8'h7B;  4'hA: seg7 = 8'h77;  4'hB: seg7 = 8'h1F;
            4'hC: seg7 = 8'h4E;  4'hD: seg7 = 8'h3D;  4'hE: seg7 = 8'h4F;  4'hF: seg7 = 8'h47;
            default: seg7 = 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] init_word(input logic [2:0] idx);
        case (idx)
            3'd0:    init_word = 16'h0C01;
            3'd1:    init_word = 16'h0900;
            3'd2:    init_word = 16'h0B07;
            3'd3:    init_word = {12'h0A0, INTENSITY_NIB};
            default: init_word = 16'h0F00;
        endcase
    endfunction

    state_e        state_q, state_d;
    phase_e        ph_q, ph_d;
    logic [2:0]    cmd_q, cmd_d;
    logic [2:0]    dig_q, dig_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [SW-1:0] shreg_q, shreg_d;
    logic [7:0]    frame_q [NB];
    logic [7:0]    frame_d [NB];
    logic          spi_clk_q, spi_clk_d, dout_q, dout_d, cs_q, cs_d, stop_q, stop_d;
    logic [10:1]   pin_q, pin_d;
    logic [SW-1:0] load_word_s;
    logic [1:0]    bsel_s;
    logic          xfer_done_s;

    // Digit d (= dig_q+1) reads byte 4k + (7-dig_q)/2; odd dig_q selects the high nibble.
    assign bsel_s = ~dig_q[2:1];

    // Word for the next transaction; chip NUM_CASCADES-1 sits in the MSBs so it shifts out first.
    always_comb begin
        load_word_s = '0;
        for (int k = 0; k < NUM_CASCADES; k++) begin
            if (state_q == ST_INIT) begin
                load_word_s[16*k +: 16] = init_word(cmd_q);
            end else begin
                load_word_s[16*k +: 16] = {4'h0, {1'b0, dig_q} + 4'd1,
                    seg7(dig_q[0] ? frame_q[FW'(4*k) + FW'(bsel_s)][7:4]
                                  : frame_q[FW'(4*k) + FW'(bsel_s)][3:0])};
            end
        end
    end

    // Sequencer and bit engine: next-state and registered-output values.
    always_comb begin
        state_d = state_q;  ph_d = ph_q;  cmd_d = cmd_q;  dig_d = dig_q;
        div_d = div_q;  bit_d = bit_q;  gap_d = gap_q;  shreg_d = shreg_q;
        frame_d = frame_q;
        spi_clk_d = spi_clk_q;  dout_d = dout_q;  cs_d = cs_q;  stop_d = 1'b0;
        xfer_done_s = 1'b0;
        case (state_q)
            ST_INIT, ST_DIGITS: begin
                case (ph_q)
                    PH_LOAD: begin
                        shreg_d = load_word_s;  dout_d = load_word_s[SW-1];
                        cs_d = 1'b0;  spi_clk_d = 1'b0;
                        div_d = '0;  bit_d = '0;  ph_d = PH_LOW;
                    end
                    PH_LOW: begin
                        if (div_q == DIV_LAST) begin
                            div_d = '0;  spi_clk_d = 1'b1;  ph_d = PH_HIGH;
                        end else begin
                            div_d = div_q + DW'(1);
                        end
                    end
                    PH_HIGH: begin
                        if (div_q == DIV_LAST) begin
                            div_d = '0;  spi_clk_d = 1'b0;
                            if (bit_q == BIT_LAST) begin
                                ph_d = PH_TAIL;
                            end else begin
                                shreg_d = shreg_q << 1;  dout_d = shreg_q[SW-2];
                                bit_d = bit_q + BW'(1);  ph_d = PH_LOW;
                            end
                        end else begin
                            div_d = div_q + DW'(1);
                        end
                    end
                    PH_TAIL: begin
                        if (div_q == DIV_LAST) begin
                            div_d = '0;  cs_d = 1'b1;  dout_d = 1'b0;  ph_d = PH_HOLD;
                        end else begin
                            div_d = div_q + DW'(1);
                        end
                    end
                    PH_HOLD: begin
                        if (div_q == HOLD_LAST) begin
                            div_d = '0;  ph_d = PH_LOAD;  xfer_done_s = 1'b1;
                        end else begin
                            div_d = div_q + DW'(1);
                        end
                    end
                    default: ph_d = PH_LOAD;
                endcase
                if (xfer_done_s && state_q == ST_INIT) begin
                    if (cmd_q == 3'd4) begin
                        cmd_d = 3'd0;  state_d = ST_LATCH;
                    end else begin
                        cmd_d = cmd_q + 3'd1;
                    end
                end else if (xfer_done_s) begin
                    if (dig_q == 3'd7) begin
                        dig_d = 3'd0;  gap_d = '0;  stop_d = 1'b1;  state_d = ST_GAP;
                    end else begin
                        dig_d = dig_q + 3'd1;
                    end
                end else begin
                    cmd_d = cmd_q;
                end
            end
            ST_LATCH: begin
                frame_d = frame;  dig_d = 3'd0;  ph_d = PH_LOAD;  state_d = ST_DIGITS;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
`ifdef MAX7219_REINIT_EN
                    state_d = ST_INIT;
`else
                    state_d = ST_LATCH;
`endif
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
        pin_d = {dig_d, state_d, stop_d, cs_d, dout_d, spi_clk_d};
    end

    // State and output registers; reset also aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;  ph_q <= PH_LOAD;  cmd_q <= 3'd0;  dig_q <= 3'd0;
            div_q <= '0;  bit_q <= '0;  gap_q <= '0;  shreg_q <= '0;
            for (int i = 0; i < NB; i++) frame_q[i] <= 8'h00;
            spi_clk_q <= 1'b0;  dout_q <= 1'b0;  cs_q <= 1'b1;  stop_q <= 1'b0;
            pin_q <= 10'd0;
        end else begin
            state_q <= state_d;  ph_q <= ph_d;  cmd_q <= cmd_d;  dig_q <= dig_d;
            div_q <= div_d;  bit_q <= bit_d;  gap_q <= gap_d;  shreg_q <= shreg_d;
            frame_q <= frame_d;
            spi_clk_q <= spi_clk_d;  dout_q <= dout_d;  cs_q <= cs_d;  stop_q <= stop_d;
            pin_q <= pin_d;
        end
    end

    assign spi.spi_clk = spi_clk_q;
    assign spi.dout    = dout_q;
    assign spi.cs      = cs_q;
    assign stop        = stop_q;
    assign pin         = pin_q;
endmodule

// File: tb/tb_max7219_display.sv
// Directed bench for max7219_display: two chips, intensity 1, spi_clk period of 4 clk.
module tb_max7219_display;
    localparam int N   = 2;
    localparam int GAP = 64;
    localparam int TMO = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  frame [4*N];
    logic        stop;
    logic [10:1] pin;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] init_exp [5] = '{32'h0C010C01, 32'h09000900, 32'h0B070B07, 32'h0A010A01, 32'h0F000F00};
    logic [31:0] old_exp  [8] = '{32'h017E017F, 32'h02470270, 32'h034F035F, 32'h043D045B,
                                  32'h054E0533, 32'h061F0679, 32'h0777076D, 32'h087B0830};
    logic [31:0] new_exp  [8] = '{32'h014E014E, 32'h025B025B, 32'h034E034E, 32'h045B045B,
                                  32'h054E054E, 32'h065B065B, 32'h074E074E, 32'h085B085B};

    max7219_display_if dif ();

    max7219_display #(.NUM_CASCADES(N), .INTENSITY(1), .CLK_DIV(2), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(rst_n), .frame(frame), .spi(dif), .stop(stop), .pin(pin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Capture one transaction: dout sampled at each spi_clk rising edge while cs is low.
    task automatic get_xfer(output logic [31:0] w, output int nbits, output int period,
                            output int stops);
        int   cyc = 0;
        int   r1 = -1;
        int   r2 = -1;
        logic prev;
        w = '0;  nbits = 0;  stops = 0;
        while (dif.cs !== 1'b0 && cyc < TMO) begin
            @(negedge clk);  cyc++;
            if (stop === 1'b1) stops++;
        end
        prev = dif.spi_clk;
        while (dif.cs === 1'b0 && cyc < TMO) begin
            @(negedge clk);  cyc++;
            if (stop === 1'b1) stops++;
            if (prev === 1'b0 && dif.spi_clk === 1'b1) begin
                w = {w[30:0], dif.dout};
                nbits++;
                if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc;
            end
            prev = dif.spi_clk;
        end
        period = r2 - r1;
        chk("xfer_timeout", 32'(cyc >= TMO), 32'd0);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] exp);
        logic [31:0] w;
        int nb, per, st;
        get_xfer(w, nb, per, st);
        chk(tag, w, exp);
    endtask

    task automatic expect_init();
        for (int i = 0; i < 5; i++) expect_word("init_word", init_exp[i]);
    endtask

    // stop must be a single-clk pulse followed by at least GAP idle cycles with cs high.
    task automatic check_gap();
        int cyc = 0;
        int idle = 0;
        while (stop !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        chk("stop_seen", 32'(stop), 32'd1);
        @(negedge clk);
        chk("stop_width", 32'(stop), 32'd0);
        while (dif.cs === 1'b1 && idle < TMO) begin @(negedge clk); idle++; end
        chk("gap_len_ok", 32'(idle >= GAP && idle < TMO), 32'd1);
`ifdef MAX7219_REINIT_EN
        expect_init();
`endif
    endtask

    initial begin
        logic [31:0] w;
        int nb, per, st, stop_sum, cyc, nr;
        logic prev;

        frame = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(dif.cs), 32'd1);
        chk("rst_spi_clk", 32'(dif.spi_clk), 32'd0);
        chk("rst_dout", 32'(dif.dout), 32'd0);
        chk("rst_stop", 32'(stop), 32'd0);
        chk("rst_pin", 32'(pin), 32'd0);
        rst_n = 1'b1;

        get_xfer(w, nb, per, st);
        chk("init0_word", w, init_exp[0]);
        chk("init0_bits", 32'(nb), 32'd32);
        chk("spi_period", 32'(per), 32'd4);
        for (int i = 1; i < 5; i++) expect_word("init_word", init_exp[i]);

        stop_sum = 0;
        for (int d = 0; d < 8; d++) begin
            get_xfer(w, nb, per, st);
            stop_sum += st;
            chk("digit_old", w, old_exp[d]);
            if (d == 2) begin
                chk("pin_state", 32'(pin[7:5]), 32'd2);
                chk("pin_digit", 32'(pin[10:8]), 32'd2);
                chk("pin_cs", 32'(pin[3]), 32'(dif.cs));
            end
        end
        chk("no_stop_in_digits", 32'(stop_sum), 32'd0);
        check_gap();

        for (int d = 0; d < 3; d++) expect_word("digit_old_pre", old_exp[d]);
        frame = '{8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'h5C};
        for (int d = 3; d < 8; d++) expect_word("digit_old_hold", old_exp[d]);
        check_gap();
        for (int d = 0; d < 8; d++) expect_word("digit_new", new_exp[d]);
        check_gap();

        // Abort the next transaction during its 10th bit.
        cyc = 0;  nr = 0;
        while (dif.cs !== 1'b0 && cyc < TMO) begin @(negedge clk); cyc++; end
        prev = dif.spi_clk;
        while (nr < 9 && cyc < TMO) begin
            @(negedge clk);  cyc++;
            if (prev === 1'b0 && dif.spi_clk === 1'b1) nr++;
            prev = dif.spi_clk;
        end
        while (dif.spi_clk !== 1'b0 && cyc < TMO) begin @(negedge clk); cyc++; end
        chk("bit10_reached", 32'(nr), 32'd9);
        rst_n = 1'b0;
        #1;
        chk("abort_cs", 32'(dif.cs), 32'd1);
        chk("abort_spi_clk", 32'(dif.spi_clk), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_pin", 32'(pin), 32'd0);
        rst_n = 1'b1;
        expect_word("restart_init0", init_exp[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
